// File: rtl/axi4l_mem_bridge_if.sv
// Memory-side request/response interface shared by the bridge and the
// accelerator address generator. A request is a one-cycle en pulse; the
// far side answers with a one-cycle valid, carrying dout for reads.
interface cnnip_mem_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  en;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  valid;

  modport master (output en, output we, output addr, output din,
                  input  dout, input valid);
  modport slave  (input  en, input  we, input  addr, input  din,
                  output dout, output valid);
endinterface

// File: rtl/axi4l_mem_bridge.sv
// AXI4-Lite slave to cnnip_mem_if bridge. One transaction in flight at a
// time, reads and writes arbitrated round-robin, and a bounded wait for the
// memory-side valid so that unmapped addresses still get a response.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for AW+W or AR; readys pulse here for the accept
// WR_REQ    | en/we high for one cycle with addr/din
// WR_WAIT   | counting cycles until valid or timeout
// WR_RESP   | bvalid held until bready
// RD_REQ    | en high for one cycle with addr, we low
// RD_WAIT   | counting cycles until valid (capture dout) or timeout
// RD_RESP   | rvalid held until rready
module axi4l_mem_bridge #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_a,
  input  logic                  arstz_aq,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  cnnip_mem_if.master           to_mem_if
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_WAIT = 3'd2;
  localparam logic [2:0] S_WR_RESP = 3'd3;
  localparam logic [2:0] S_RD_REQ  = 3'd4;
  localparam logic [2:0] S_RD_WAIT = 3'd5;
  localparam logic [2:0] S_RD_RESP = 3'd6;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [2:0]            state;
  logic [CNT_W-1:0]      to_cnt;
  logic                  last_was_write;
  logic                  en_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;

  logic wr_elig;
  logic rd_elig;
  logic pick_write;
  logic timeout_hit;

  assign to_mem_if.en   = en_q;
  assign to_mem_if.we   = we_q;
  assign to_mem_if.addr = addr_q;
  assign to_mem_if.din  = din_q;

  // Eligibility and round-robin pick; a write needs both AW and W present.
  always_comb begin
    wr_elig     = s_axi_awvalid && s_axi_wvalid;
    rd_elig     = s_axi_arvalid;
    pick_write  = wr_elig && (!rd_elig || !last_was_write);
    timeout_hit = (to_cnt == CNT_W'(TIMEOUT - 1));
  end

  // Transaction sequencer; every output is a register so nothing glitches
  // into the downstream bank decode.
  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      state          <= S_IDLE;
      to_cnt         <= '0;
      last_was_write <= 1'b0;
      s_axi_awready  <= 1'b0;
      s_axi_wready   <= 1'b0;
      s_axi_arready  <= 1'b0;
      s_axi_bvalid   <= 1'b0;
      s_axi_bresp    <= 2'b00;
      s_axi_rvalid   <= 1'b0;
      s_axi_rresp    <= 2'b00;
      s_axi_rdata    <= '0;
      en_q           <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      din_q          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (s_axi_awready) begin
            // Accept cycle for a write: partial strobes are refused without
            // touching memory, since the banks only take full words.
            s_axi_awready  <= 1'b0;
            s_axi_wready   <= 1'b0;
            last_was_write <= 1'b1;
            if (&s_axi_wstrb) begin
              en_q   <= 1'b1;
              we_q   <= 1'b1;
              addr_q <= s_axi_awaddr;
              din_q  <= s_axi_wdata;
              state  <= S_WR_REQ;
            end else begin
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= RESP_SLVERR;
              state        <= S_WR_RESP;
            end
          end else if (s_axi_arready) begin
            s_axi_arready  <= 1'b0;
            last_was_write <= 1'b0;
            en_q           <= 1'b1;
            we_q           <= 1'b0;
            addr_q         <= s_axi_araddr;
            din_q          <= '0;
            state          <= S_RD_REQ;
          end else if (pick_write) begin
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
          end else if (rd_elig) begin
            s_axi_arready <= 1'b1;
          end
        end
        S_WR_REQ, S_RD_REQ: begin
          en_q   <= 1'b0;
          we_q   <= 1'b0;
          addr_q <= '0;
          din_q  <= '0;
          to_cnt <= '0;
          state  <= (state == S_WR_REQ) ? S_WR_WAIT : S_RD_WAIT;
        end
        S_WR_WAIT: begin
          if (to_mem_if.valid) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= RESP_OKAY;
            state        <= S_WR_RESP;
          end else if (timeout_hit) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= RESP_SLVERR;
            state        <= S_WR_RESP;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        S_RD_WAIT: begin
          if (to_mem_if.valid) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rdata  <= to_mem_if.dout;
            state        <= S_RD_RESP;
          end else if (timeout_hit) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rresp  <= RESP_SLVERR;
            s_axi_rdata  <= '0;
            state        <= S_RD_RESP;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        S_WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
            state        <= S_IDLE;
          end
        end
        S_RD_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= 2'b00;
            s_axi_rdata  <= '0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4l_mem_bridge.sv
// Bench for axi4l_mem_bridge: directed AXI4-Lite traffic against a simple
// memory responder, with expected memory requests and AXI responses queued
// at stimulus time and compared by a monitor as they appear.
module tb_axi4l_mem_bridge;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] din;
  } mreq_t;

  logic          clk_a = 1'b0;
  logic          arstz_aq = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;

  cnnip_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  axi4l_mem_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_a         (clk_a),
    .arstz_aq      (arstz_aq),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .to_mem_if     (mem_if)
  );

  always #5 clk_a = ~clk_a;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int resp_done = 0;

  rsp_t  exp_b_q[$];
  rsp_t  exp_r_q[$];
  mreq_t exp_m_q[$];

  int          mem_lat   = 1;
  bit          mem_early = 1'b0;
  logic [31:0] rd_data   = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_a);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Memory responder: valid for one cycle mem_lat cycles after en
  // (mem_lat == 0 never answers); optional bogus valid during the en cycle.
  initial begin
    mem_if.valid = 1'b0;
    mem_if.dout  = '0;
    forever begin
      @(negedge clk_a);
      if (mem_if.en) begin
        if (mem_early) begin
          mem_if.valid = 1'b1;
          mem_if.dout  = 32'hBAD0_BAD0;
        end
        @(posedge clk_a);
        #1;
        mem_if.valid = 1'b0;
        mem_if.dout  = '0;
        if (mem_lat > 0) begin
          if (mem_lat > 1) begin
            repeat (mem_lat - 1) @(posedge clk_a);
            #1;
          end
          mem_if.valid = 1'b1;
          mem_if.dout  = rd_data;
          @(posedge clk_a);
          #1;
          mem_if.valid = 1'b0;
          mem_if.dout  = '0;
        end
      end
    end
  end

  // Monitor: memory-side requests, ready pulses and AXI responses.
  initial begin
    logic en_prev = 1'b0, aw_prev = 1'b0, ar_prev = 1'b0;
    logic bv_prev = 1'b0, rv_prev = 1'b0;
    logic [1:0]  b_resp_q = '0, r_resp_q = '0;
    logic [31:0] r_data_q = '0;
    int last_en = 0, b_rise = 0, r_rise = 0;
    rsp_t  er;
    mreq_t em;
    forever begin
      @(negedge clk_a);
      if (arstz_aq) begin
        if (mem_if.en) begin
          chk("en_one_cycle", 64'(en_prev), 64'(0));
          if (exp_m_q.size() == 0) begin
            chk("mem_unexpected_en", 64'(1), 64'(0));
          end else begin
            em = exp_m_q.pop_front();
            chk("mem_we",   64'(mem_if.we),   64'(em.we));
            chk("mem_addr", 64'(mem_if.addr), 64'(em.addr));
            chk("mem_din",  64'(mem_if.din),  64'(em.din));
          end
          last_en = cyc;
        end else begin
          chk("mem_idle", 64'({mem_if.we, mem_if.addr, mem_if.din}), 64'(0));
        end
        if (awready || wready) begin
          chk("aw_w_together", 64'(awready), 64'(wready));
          chk("aw_ar_exclusive", 64'(arready), 64'(0));
          chk("awready_pulse", 64'(aw_prev), 64'(0));
        end
        if (arready) chk("arready_pulse", 64'(ar_prev), 64'(0));
        if (bvalid) begin
          if (!bv_prev) begin
            b_rise   = cyc;
            b_resp_q = bresp;
          end else begin
            chk("bresp_stable", 64'(bresp), 64'(b_resp_q));
          end
          if (bready) begin
            if (exp_b_q.size() == 0) begin
              chk("b_unexpected", 64'(1), 64'(0));
            end else begin
              er = exp_b_q.pop_front();
              chk("bresp", 64'(bresp), 64'(er.resp));
              if (er.lat >= 0) chk("b_latency", 64'(b_rise - last_en), 64'(er.lat));
            end
            resp_done++;
          end
        end
        if (rvalid) begin
          if (!rv_prev) begin
            r_rise   = cyc;
            r_resp_q = rresp;
            r_data_q = rdata;
          end else begin
            chk("rresp_stable", 64'({rresp, rdata}), 64'({r_resp_q, r_data_q}));
          end
          if (rready) begin
            if (exp_r_q.size() == 0) begin
              chk("r_unexpected", 64'(1), 64'(0));
            end else begin
              er = exp_r_q.pop_front();
              chk("rresp", 64'(rresp), 64'(er.resp));
              chk("rdata", 64'(rdata), 64'(er.data));
              chk("r_latency", 64'(r_rise - last_en), 64'(er.lat));
            end
            resp_done++;
          end
        end
      end
      en_prev = mem_if.en;
      aw_prev = awready;
      ar_prev = arready;
      bv_prev = bvalid;
      rv_prev = rvalid;
    end
  end

  task automatic axi_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int lat, input int bdly);
    rsp_t  r;
    mreq_t m;
    int    n;
    r.resp = (&s) ? 2'b00 : 2'b10;
    r.data = '0;
    r.lat  = (&s) ? lat + 1 : -1;
    exp_b_q.push_back(r);
    if (&s) begin
      m.we = 1'b1; m.addr = a; m.din = d;
      exp_m_q.push_back(m);
    end
    mem_lat = lat;
    @(posedge clk_a); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    bready = (bdly == 0);
    for (n = 0; n < 20; n++) begin
      @(negedge clk_a);
      if (awready) break;
    end
    if (n == 20) chk("wr_accept_timeout", 64'(1), 64'(0));
    @(posedge clk_a); #1;
    awvalid = 1'b0; wvalid = 1'b0; awaddr = '0; wdata = '0; wstrb = '0;
    if (bdly > 0) begin
      for (n = 0; n < 64; n++) begin
        @(negedge clk_a);
        if (bvalid) break;
      end
      if (n == 64) chk("bvalid_timeout", 64'(1), 64'(0));
      repeat (bdly) @(posedge clk_a);
      #1 bready = 1'b1;
    end
    for (n = 0; n < 64; n++) begin
      @(negedge clk_a);
      if (bvalid && bready) break;
    end
    if (n == 64) chk("b_handshake_timeout", 64'(1), 64'(0));
    @(posedge clk_a); #1;
    bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [11:0] a, input int lat, input logic [31:0] d, input bit early);
    rsp_t  r;
    mreq_t m;
    int    n;
    r.resp = (lat > 0) ? 2'b00 : 2'b10;
    r.data = (lat > 0) ? d : 32'h0;
    r.lat  = (lat > 0) ? lat + 1 : TO + 1;
    exp_r_q.push_back(r);
    m.we = 1'b0; m.addr = a; m.din = '0;
    exp_m_q.push_back(m);
    mem_lat = lat; rd_data = d; mem_early = early;
    @(posedge clk_a); #1;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk_a);
      if (arready) break;
    end
    if (n == 20) chk("rd_accept_timeout", 64'(1), 64'(0));
    @(posedge clk_a); #1;
    arvalid = 1'b0; araddr = '0;
    for (n = 0; n < 64; n++) begin
      @(negedge clk_a);
      if (rvalid && rready) break;
    end
    if (n == 64) chk("r_handshake_timeout", 64'(1), 64'(0));
    @(posedge clk_a); #1;
    rready = 1'b0; mem_early = 1'b0;
  endtask

  initial begin
    rsp_t  r;
    mreq_t m;
    int    target;
    int    n;

    // All three requests pending from reset: expect W, R, W, R.
    mem_lat = 1;
    rd_data = 32'hCAFE_0001;
    for (int i = 0; i < 2; i++) begin
      m.we = 1'b1; m.addr = 12'h010; m.din = 32'h1111_1111;
      exp_m_q.push_back(m);
      m.we = 1'b0; m.addr = 12'h020; m.din = 32'h0;
      exp_m_q.push_back(m);
      r.resp = 2'b00; r.data = 32'h0; r.lat = 2;
      exp_b_q.push_back(r);
      r.data = 32'hCAFE_0001;
      exp_r_q.push_back(r);
    end
    awaddr = 12'h010; wdata = 32'h1111_1111; wstrb = 4'hF;
    araddr = 12'h020;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;

    repeat (3) @(posedge clk_a);
    @(negedge clk_a);
    chk("reset_axi_outputs", 64'({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}), 64'(0));
    chk("reset_mem_outputs", 64'({mem_if.en, mem_if.we, mem_if.addr, mem_if.din}), 64'(0));
    @(posedge clk_a); #1;
    arstz_aq = 1'b1;

    target = resp_done + 4;
    for (n = 0; n < 200; n++) begin
      @(negedge clk_a); #1;
      if (resp_done >= target) break;
    end
    if (n == 200) chk("rr_responses_timeout", 64'(1), 64'(0));
    @(posedge clk_a); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    repeat (2) @(posedge clk_a);

    // AW alone then W alone must never be accepted.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_a); #1;
      awvalid = (i < 3); wvalid = (i >= 3); wstrb = 4'hF;
      @(negedge clk_a);
      chk("half_write_not_accepted", 64'({awready, wready}), 64'(0));
    end
    @(posedge clk_a); #1;
    awvalid = 1'b0; wvalid = 1'b0; wstrb = '0;
    @(negedge clk_a);
    chk("half_write_not_accepted", 64'({awready, wready}), 64'(0));

    axi_wr(12'h104, 32'hDEAD_BEEF, 4'hF, 2, 0);
    axi_rd(12'h308, 1, 32'h1234_5678, 1'b1);
    axi_rd(12'hF00, 0, 32'h0, 1'b0);
    axi_rd(12'h0F4, 3, 32'hA5A5_0F0F, 1'b0);
    axi_wr(12'h200, 32'h0000_0055, 4'b0011, 0, 5);
    axi_wr(12'h3FC, 32'h0BAD_F00D, 4'hF, 4, 2);

    // Reset while waiting on the memory side: abandoned, no response.
    m.we = 1'b0; m.addr = 12'h2C0; m.din = '0;
    exp_m_q.push_back(m);
    mem_lat = 0;
    @(posedge clk_a); #1;
    araddr = 12'h2C0; arvalid = 1'b1; rready = 1'b1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk_a);
      if (arready) break;
    end
    if (n == 20) chk("rst_rd_accept_timeout", 64'(1), 64'(0));
    @(posedge clk_a); #1;
    arvalid = 1'b0; araddr = '0;
    repeat (4) @(posedge clk_a);
    @(negedge clk_a); #2;
    arstz_aq = 1'b0;
    #1;
    chk("async_rst_axi", 64'({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}), 64'(0));
    chk("async_rst_mem", 64'({mem_if.en, mem_if.we, mem_if.addr, mem_if.din}), 64'(0));
    repeat (2) @(posedge clk_a);
    #1;
    arstz_aq = 1'b1;
    rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_a);
      chk("post_rst_idle", 64'({awready, wready, arready, bvalid, rvalid}), 64'(0));
    end

    axi_rd(12'h044, 2, 32'h7777_1234, 1'b0);
    axi_wr(12'h048, 32'h8888_4321, 4'hF, 1, 0);

    repeat (4) @(posedge clk_a);
    chk("exp_mem_drained", 64'(exp_m_q.size()), 64'(0));
    chk("exp_b_drained",   64'(exp_b_q.size()), 64'(0));
    chk("exp_r_drained",   64'(exp_r_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
